// File: rtl/fixedp_div.sv
// fixedp_div: sequential signed fixed-point divider (restoring, one quotient bit per cycle)
// Ports: CLK/RST (sync, active-high); start request sampled in IDLE; in1 Q(WI1.WF1) dividend;
// in2 Q(WI2.WF2) divisor; busy while dividing; done one-cycle pulse; out Q(WIO.WFO) quotient;
// OVF saturated; DIVZ divisor zero. Define FIXEDP_DIV_ROUND_EN to round half away from zero.
module fixedp_div #(
  parameter int WI1 = 5,
  parameter int WF1 = 4,
  parameter int WI2 = 7,
  parameter int WF2 = 3,
  parameter int WIO = 8,
  parameter int WFO = 4
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       start,
  input  logic signed [WI1+WF1-1:0]  in1,
  input  logic signed [WI2+WF2-1:0]  in2,
  output logic                       busy,
  output logic                       done,
  output logic signed [WIO+WFO-1:0]  out,
  output logic                       OVF,
  output logic                       DIVZ
);
  localparam int W1 = WI1 + WF1;
  localparam int W2 = WI2 + WF2;
  localparam int WO = WIO + WFO;
  localparam int QW = WI1 + WFO + WF2;
  localparam int SH = WFO + WF2 - WF1;
`ifdef FIXEDP_DIV_ROUND_EN
  localparam int RND = 1;
`else
  localparam int RND = 0;
`endif
  localparam int NW = QW + RND;
  localparam int MW = (QW + 1 > WO + 1) ? QW + 1 : WO + 1;
  localparam int CW = $clog2(NW + 1);
  localparam logic [MW-1:0] LIM = MW'(1) << (WO - 1);
  localparam logic [WO-1:0] MAXV = {1'b0, {(WO-1){1'b1}}};
  localparam logic [WO-1:0] MINV = {1'b1, {(WO-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;
  state_t r_state, w_next;

  logic [NW-1:0] r_num, r_q;
  logic [W2-1:0] r_den, r_rem;
  logic [CW-1:0] r_cnt;
  logic          r_s1, r_s2;
  logic [W1-1:0] w_a1;
  logic [W2-1:0] w_a2;
  logic [W2:0]   w_trial, w_nrem;
  logic          w_ge, w_neg, w_ovf;
  logic [MW-1:0] w_mag;
  logic [WO-1:0] w_res;

  assign w_a1 = in1[W1-1] ? -in1 : in1;
  assign w_a2 = in2[W2-1] ? -in2 : in2;
  assign busy = r_state != IDLE;

  always_comb begin
    w_trial = {r_rem, r_num[NW-1]};
    w_ge    = w_trial >= {1'b0, r_den};
    w_nrem  = w_ge ? w_trial - {1'b0, r_den} : w_trial;
`ifdef FIXEDP_DIV_ROUND_EN
    // the extra low quotient bit is the half bit: adding it rounds the magnitude half-up
    w_mag   = MW'(r_q[NW-1:1]) + MW'(r_q[0]);
`else
    w_mag   = MW'(r_q);
`endif
    w_neg   = r_s1 ^ r_s2;
    // a negative result may reach exactly LIM (the min value) without overflowing
    w_ovf   = w_neg ? (w_mag > LIM) : (w_mag > LIM - MW'(1));
    w_res   = w_ovf ? (w_neg ? MINV : MAXV) : (w_neg ? -w_mag[WO-1:0] : w_mag[WO-1:0]);
  end

  always_comb begin
    w_next = r_state == IDLE ? (start ? CALC : IDLE) :
             r_state == CALC ? (r_cnt == CW'(NW - 1) ? FIN : CALC) : IDLE;
  end

  always_ff @(posedge CLK) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      done  <= 1'b0;
      out   <= '0;
      OVF   <= 1'b0;
      DIVZ  <= 1'b0;
      r_cnt <= '0;
    end else begin
      done <= r_state == FIN;
      if (r_state == IDLE && start) begin
        r_num <= NW'(w_a1) << (SH + RND);
        r_den <= w_a2;
        r_s1  <= in1[W1-1];
        r_s2  <= in2[W2-1];
        r_rem <= '0;
        r_q   <= '0;
        r_cnt <= '0;
      end
      if (r_state == CALC) begin
        r_rem <= W2'(w_nrem);
        r_q   <= {r_q[NW-2:0], w_ge};
        r_num <= r_num << 1;
        r_cnt <= r_cnt + CW'(1);
      end
      if (r_state == FIN) begin
        out  <= r_den == '0 ? (r_s1 ? MINV : MAXV) : w_res;
        OVF  <= r_den == '0 || w_ovf;
        DIVZ <= r_den == '0;
      end
    end
  end
endmodule

// File: tb/tb_fixedp_div.sv
// tb_fixedp_div: directed-vector self-checking bench for fixedp_div at default widths
module tb_fixedp_div;
`ifdef FIXEDP_DIV_ROUND_EN
  localparam int LAT = 14;
  localparam logic [11:0] Q23 = 12'h00B;
`else
  localparam int LAT = 13;
  localparam logic [11:0] Q23 = 12'h00A;
`endif
  logic        CLK = 0, RST = 1, start = 0;
  logic [8:0]  in1 = '0;
  logic [9:0]  in2 = '0;
  logic        busy, done, OVF, DIVZ;
  logic [11:0] out;
  int total = 0, bad = 0, lat = 0, nd = 0;

  fixedp_div dut (.CLK(CLK), .RST(RST), .start(start), .in1(in1), .in2(in2),
                  .busy(busy), .done(done), .out(out), .OVF(OVF), .DIVZ(DIVZ));

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic kick(input logic [8:0] a, input logic [9:0] b);
    @(negedge CLK);
    in1 = a; in2 = b; start = 1;
    @(posedge CLK);
    #1 start = 0; in1 = 9'($urandom); in2 = 10'($urandom);
    lat = 0;
  endtask

  task automatic wait_done();
    while (!done && lat < 40) begin
      @(posedge CLK);
      #1 lat++;
    end
  endtask

  task automatic vec(input string tag, input logic [8:0] a, input logic [9:0] b,
                     input logic [11:0] eo, input logic eovf, input logic edz);
    kick(a, b);
    wait_done();
    chk({tag, ".lat"}, lat, LAT);
    chk({tag, ".out"}, out, eo);
    chk({tag, ".ovf"}, OVF, eovf);
    chk({tag, ".divz"}, DIVZ, edz);
    @(posedge CLK);
    #1 chk({tag, ".pulse"}, {busy, done}, 2'b00);
    chk({tag, ".hold"}, out, eo);
  endtask

  task automatic count_done(input int n);
    nd = 0;
    repeat (n) begin
      @(posedge CLK);
      #1 nd += int'(done);
    end
  endtask

  initial begin
    repeat (3) @(posedge CLK);
    #1 chk("rst", {busy, done, OVF, DIVZ, out}, 16'h0);
    @(negedge CLK) RST = 0;
    vec("one",   9'h010, 10'h008, 12'h010, 0, 0);
    vec("sign",  9'h1C8, 10'h010, 12'hFE4, 0, 0);
    vec("div23", 9'h020, 10'h018, Q23,     0, 0);
    vec("neg13", 9'h1F0, 10'h018, 12'hFFB, 0, 0);
    vec("m2",    9'h0F0, 10'h3F0, 12'hF88, 0, 0);
    vec("bigp",  9'h0FF, 10'h001, 12'h7F8, 0, 0);
    vec("bign",  9'h0FF, 10'h3FF, 12'h808, 0, 0);
    vec("satp",  9'h100, 10'h3FF, 12'h7FF, 1, 0);
    vec("exmin", 9'h100, 10'h001, 12'h800, 0, 0);
    vec("dz_p",  9'h010, 10'h000, 12'h7FF, 1, 1);
    vec("dz_n",  9'h1F0, 10'h000, 12'h800, 1, 1);
    vec("dz_0",  9'h000, 10'h000, 12'h7FF, 1, 1);
    // start while busy must be ignored
    kick(9'h010, 10'h008);
    repeat (4) @(posedge CLK);
    @(negedge CLK);
    in1 = 9'h0F0; in2 = 10'h3F0; start = 1;
    @(posedge CLK);
    #1 start = 0; lat = 5;
    wait_done();
    chk("busy_st.lat", lat, LAT);
    chk("busy_st.out", out, 12'h010);
    count_done(30);
    chk("busy_st.extra", nd, 0);
    // start during FIN must be ignored
    kick(9'h1C8, 10'h010);
    while (lat < LAT - 1) begin
      @(posedge CLK);
      #1 lat++;
    end
    @(negedge CLK) start = 1;
    @(posedge CLK);
    #1 start = 0;
    chk("fin_st.done", done, 1'b1);
    chk("fin_st.busy", busy, 1'b0);
    chk("fin_st.out", out, 12'hFE4);
    count_done(30);
    chk("fin_st.extra", nd, 0);
    // reset mid-calculation aborts without a done pulse
    kick(9'h100, 10'h3FF);
    repeat (5) @(posedge CLK);
    @(negedge CLK) RST = 1;
    @(posedge CLK);
    #1 chk("abort.outs", {busy, done, OVF, DIVZ, out}, 16'h0);
    @(negedge CLK) RST = 0;
    count_done(30);
    chk("abort.extra", nd, 0);
    vec("after", 9'h020, 10'h018, Q23, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fixedp_div.md
FIXEDP_DIV -- requirements
Module: fixedp_div

Interface
- REQ-001: Parameter WI1, default 5, integer bits of dividend in1 (sign included).
- REQ-002: Parameter WF1, default 4, fractional bits of in1.
- REQ-003: Parameter WI2, default 7, integer bits of divisor in2 (sign included).
- REQ-004: Parameter WF2, default 3, fractional bits of in2.
- REQ-005: Parameter WIO, default 8, integer bits of out (sign included).
- REQ-006: Parameter WFO, default 4, fractional bits of out; constraint WFO+WF2 >= WF1.
- REQ-007: CLK  input  1  sole clock, all state updates on rising edge.
- REQ-008: RST  input  1  synchronous, active-high reset.
- REQ-009: start  input  1  request pulse; sampled only in IDLE.
- REQ-010: in1  input  WI1+WF1  signed two's-complement dividend.
- REQ-011: in2  input  WI2+WF2  signed two's-complement divisor.
- REQ-012: busy  output  1  high while a division is in progress.
- REQ-013: done  output  1  one-cycle pulse when out/OVF/DIVZ update.
- REQ-014: out  output  WIO+WFO  signed quotient, held until the next completion.
- REQ-015: OVF  output  1  quotient saturated; held with out.
- REQ-016: DIVZ  output  1  divisor was zero; held with out.

Function
- REQ-017: FSM states are IDLE, CALC, FIN; reset state is IDLE.
- REQ-018: In IDLE with start=1, in1 and in2 are registered, the FSM enters CALC, and busy rises on the same edge.
- REQ-019: Define QW = WI1+WFO+WF2 (12 at defaults); CALC performs restoring division on magnitudes, one quotient bit per cycle for QW cycles, with numerator |in1| left-shifted by WFO+WF2-WF1.
- REQ-020: FIN applies the sign (in1 sign XOR in2 sign), saturates, and updates out/OVF/DIVZ; done=1 for exactly that cycle; the FSM then returns to IDLE with busy=0.
- REQ-021: Latency: start sampled at edge k gives done high in the cycle after edge k+QW+1 (13 edges at defaults), fixed for all operands including divide-by-zero.
- REQ-022: The default result is truncated toward zero.
- REQ-023: A result above the max positive value gives out = 0 followed by all ones, and OVF=1; a result below the min gives out = 1 followed by all zeros, and OVF=1; an exact min value is not overflow.
- REQ-024: With in2=0, DIVZ=1 and OVF=1; out = max positive if in1 >= 0, else min negative.
- REQ-025: start while busy=1 is ignored, with no queuing and no corruption of the operation in flight.
- REQ-026: start asserted in the FIN cycle is ignored; a new request is accepted only in IDLE.
- REQ-027: in1 and in2 may change freely after the accepting edge.

Reset
- REQ-028: RST=1 at any edge forces IDLE, busy=0, done=0, out=0, OVF=0, DIVZ=0, aborting any operation in flight with no done pulse.
- REQ-029: RST has priority over start.

Configuration
- REQ-030: Macro FIXEDP_DIV_ROUND_EN, when defined, computes one extra quotient bit and rounds half away from zero; CALC lasts QW+1 cycles and latency is QW+2 edges.
- REQ-031: Without FIXEDP_DIV_ROUND_EN, results are truncated toward zero and latency is QW+1 edges.
- REQ-032: Saturation and divide-by-zero rules are identical with and without FIXEDP_DIV_ROUND_EN; saturation is evaluated after rounding.

Verification (defaults: in1 Q5.4, in2 Q7.3, out Q8.4)
- REQ-033: Basic divide and latency: in1=9'h010 (1.0), in2=10'h008 (1.0), start -> out=12'h010, OVF=0, DIVZ=0, done exactly 13 edges after start (14 with ROUND_EN).
- REQ-034: Sign handling: in1=9'h1C8 (-3.5), in2=10'h010 (2.0) -> out=12'hFE4 (-1.75), OVF=0.
- REQ-035: Rounding: in1=9'h020 (2.0), in2=10'h018 (3.0) -> out=12'h00A truncated; out=12'h00B with FIXEDP_DIV_ROUND_EN.
- REQ-036: Saturation boundary: in1=9'h100 (-16), in2=10'h3FF (-0.125) -> out=12'h7FF, OVF=1; in1=9'h100, in2=10'h001 (0.125) -> out=12'h800, OVF=0.
- REQ-037: Divide by zero: in1=9'h010, in2=0 -> out=12'h7FF, DIVZ=1, OVF=1; in1=9'h1F0, in2=0 -> out=12'h800, DIVZ=1, OVF=1.
- REQ-038: Control: start pulsed at cycle 5 of a busy operation is ignored and the first result is unchanged; RST at cycle 6 of CALC gives all outputs 0 on the next cycle, no done pulse, and a following request completes normally.
